bist_scheduler: RTL and testbench

//  Shares one BIST engine (LFSR pattern generator + MISR compactor + CUT mux) between

---
 rtl/bist_scheduler_pkg.sv | 16 +
 rtl/bist_scheduler_rr_arbiter.sv | 30 +++
 rtl/bist_scheduler.sv | 107 ++++++++++
 tb/tb_bist_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bist_scheduler_pkg.sv
// bist_scheduler_pkg: FSM state encoding and counter sizing shared by the BIST scheduler.
package bist_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CMP,
        S_DONE
    } state_t;

    function automatic int cnt_w(input int n_patterns);
        return $clog2(n_patterns + 1);
    endfunction

endpackage

// File: rtl/bist_scheduler_rr_arbiter.sv
// bist_scheduler_rr_arbiter: combinational round-robin pick of the first pending index after i_last.
module bist_scheduler_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_pending,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_idx
);

    localparam int IW = $clog2(NREQ);

    logic          w_found;
    logic [IW-1:0] w_j;

    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        w_j     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_j = IW'((int'(i_last) + k) % NREQ);
            if (!w_found && i_pending[w_j]) begin
                w_found = 1'b1;
                o_idx   = w_j;
            end
        end
        o_grant = w_found ? NREQ'(1) << o_idx : '0;
    end

endmodule

// File: rtl/bist_scheduler.sv
// bist_scheduler: shares one BIST engine among NREQ requesters; edge-latched requests,
// round-robin grant, seed -> N_PATTERNS test cycles -> registered signature compare.
module bist_scheduler
    import bist_scheduler_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int N_PATTERNS = 64,
    parameter int SIG_W      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_start,
    input  logic [SIG_W-1:0]        i_misr_sig,
    input  logic [NREQ*SIG_W-1:0]   i_golden,
    output logic [NREQ-1:0]         o_cut_sel,
    output logic                    o_lfsr_load,
    output logic                    o_misr_clr,
    output logic                    o_test_en,
    output logic                    o_running,
    output logic                    o_bist_end,
    output logic                    o_pass,
    output logic [$clog2(NREQ)-1:0] o_result_id
);

    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = cnt_w(N_PATTERNS);

    state_t           r_state, w_next;
    logic [NREQ-1:0]  r_start_q, r_pending, r_grant;
    logic [NREQ-1:0]  w_grant, w_edge, w_mask;
    logic [IW-1:0]    r_last, w_grant_idx, r_result_id;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pass, w_cnt_last, w_match;
    logic [SIG_W-1:0] w_gold [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_gold
        assign w_gold[g] = i_golden[g*SIG_W +: SIG_W];
    end

    bist_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_pending (r_pending),
        .i_last    (r_last),
        .o_grant   (w_grant),
        .o_idx     (w_grant_idx)
    );

    // In IDLE the mask is the grant being issued (0 if none); otherwise edges from the active requester are dropped.
    assign w_edge     = i_start & ~r_start_q;
    assign w_mask     = (r_state == S_IDLE) ? w_grant : r_grant;
    assign w_cnt_last = r_cnt == CNT_W'(N_PATTERNS - 1);
    assign w_match    = i_misr_sig == w_gold[r_last];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = |r_pending ? S_INIT : S_IDLE;
            S_INIT:  w_next = S_RUN;
            S_RUN:   w_next = w_cnt_last ? S_CMP : S_RUN;
            S_CMP:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_lfsr_load = r_state == S_INIT;
        o_misr_clr  = r_state == S_INIT;
        o_test_en   = r_state == S_RUN;
        o_running   = r_state inside {S_INIT, S_RUN, S_CMP};
        o_bist_end  = r_state == S_DONE;
        o_cut_sel   = o_running ? r_grant : '0;
    end

    // start_q resets to all-ones so a start held through reset is not seen as an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_start_q   <= '1;
            r_pending   <= '0;
            r_grant     <= '0;
            r_last      <= IW'(NREQ - 1);
            r_cnt       <= '0;
            r_pass      <= 1'b0;
            r_result_id <= '0;
        end else begin
            r_start_q <= i_start;
            r_pending <= (r_pending | w_edge) & ~w_mask;
            r_cnt     <= (r_state == S_RUN && !w_cnt_last) ? r_cnt + CNT_W'(1) : '0;
            if (r_state == S_IDLE && |r_pending) begin
                r_grant <= w_grant;
                r_last  <= w_grant_idx;
            end
            if (r_state == S_CMP) begin
                r_pass      <= w_match;
                r_result_id <= r_last;
            end
        end
    end

    assign o_pass      = r_pass;
    assign o_result_id = r_result_id;

endmodule

// File: tb/tb_bist_scheduler.sv
// tb_bist_scheduler: directed checks of grant order, run sequencing, results and reset abort.
module tb_bist_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start;
    logic [3:0]  mism;
    logic [7:0]  misr;
    logic [31:0] golden = {8'hC3, 8'h5A, 8'h3C, 8'hA5};
    logic [3:0]  cut_sel;
    logic        lfsr_load, misr_clr, test_en, running, bist_end, pass;
    logic [1:0]  result_id;

    int n_pass = 0;
    int n_tot  = 0;
    int n_end  = 0;
    int n_bad  = 0;
    int te_cnt = 0;
    int q_te[$];
    logic [3:0] q_sel[$];
    logic [3:0] exp_sel [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clk = ~clk;

    bist_scheduler #(.NREQ(4), .N_PATTERNS(8), .SIG_W(8)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_misr_sig  (misr),
        .i_golden    (golden),
        .o_cut_sel   (cut_sel),
        .o_lfsr_load (lfsr_load),
        .o_misr_clr  (misr_clr),
        .o_test_en   (test_en),
        .o_running   (running),
        .o_bist_end  (bist_end),
        .o_pass      (pass),
        .o_result_id (result_id)
    );

    // Datapath stand-in: signature equals the selected golden, inverted for requesters flagged in mism.
    always_comb begin
        misr = 8'h00;
        for (int i = 0; i < 4; i++)
            if (cut_sel[i]) misr = golden[i*8 +: 8] ^ (mism[i] ? 8'hFF : 8'h00);
    end

    always @(negedge clk) begin
        if (rst) te_cnt = 0;
        else begin
            if (cut_sel != 4'b0000 && !$onehot(cut_sel)) n_bad++;
            if (test_en) te_cnt++;
            if (lfsr_load) q_sel.push_back(cut_sel);
            if (bist_end) begin
                n_end++;
                q_te.push_back(te_cnt);
                te_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 4'b0000; mism = 4'b0000;
        step(2);
        chk("rst_cut_sel", cut_sel, 0);
        chk("rst_running", running, 0);
        chk("rst_bist_end", bist_end, 0);
        chk("rst_pass", pass, 0);
        chk("rst_result_id", result_id, 0);
        chk("rst_test_en", test_en, 0);
        chk("rst_load_clr", {lfsr_load, misr_clr}, 0);
        rst = 1'b0;
        step(1);

        // single run on requester 0
        start = 4'b0001;
        step(1); chk("t1_idle_after_edge", running, 0);
        step(1);
        chk("t1_lfsr_load", lfsr_load, 1);
        chk("t1_misr_clr", misr_clr, 1);
        chk("t1_cut_sel", cut_sel, 4'b0001);
        chk("t1_init_test_en", test_en, 0);
        step(1); chk("t1_run_test_en", test_en, 1);
        step(8);
        chk("t1_cmp_test_en", test_en, 0);
        chk("t1_cmp_running", running, 1);
        step(1);
        chk("t1_bist_end", bist_end, 1);
        chk("t1_pass", pass, 1);
        chk("t1_result_id", result_id, 0);
        chk("t1_done_cut_sel", cut_sel, 0);
        step(1);
        chk("t1_end_pulse", bist_end, 0);
        chk("t1_pass_held", pass, 1);
        chk("t1_te_cycles", q_te.size() > 0 ? q_te[q_te.size()-1] : -1, 8);

        // simultaneous requests 1 and 3, mismatch on 3
        start = 4'b0000; step(1);
        mism = 4'b1000; start = 4'b1010;
        step(12);
        chk("t2_end_a", bist_end, 1);
        chk("t2_id_a", result_id, 1);
        chk("t2_pass_a", pass, 1);
        step(1);
        chk("t2_gap_idle", running, 0);
        step(1);
        chk("t2_cut_sel_b", cut_sel, 4'b1000);
        chk("t2_load_b", lfsr_load, 1);
        step(10);
        chk("t2_end_b", bist_end, 1);
        chk("t2_id_b", result_id, 3);
        chk("t2_pass_b", pass, 0);
        step(1);
        chk("t2_pass_b_held", pass, 0);
        chk("t2_n_end", n_end, 3);

        // own re-edge dropped, other requester's edge kept
        start = 4'b0000; mism = 4'b0000; step(1);
        start = 4'b0100;
        step(4);
        chk("t3_run_test_en", test_en, 1);
        chk("t3_cut_sel", cut_sel, 4'b0100);
        start = 4'b0000;
        step(1); start = 4'b0101;
        step(7);
        chk("t3_end_a", bist_end, 1);
        chk("t3_id_a", result_id, 2);
        step(2);
        chk("t3_queued_run", cut_sel, 4'b0001);
        step(10);
        chk("t3_end_b", bist_end, 1);
        chk("t3_id_b", result_id, 0);
        step(20);
        chk("t3_no_rerun", n_end, 5);
        chk("t3_idle", running, 0);

        // reset mid-run with start held
        start = 4'b0000; step(1);
        start = 4'b0010;
        step(5);
        chk("t4_run_test_en", test_en, 1);
        chk("t4_cut_sel", cut_sel, 4'b0010);
        #2 rst = 1'b1;
        #1;
        chk("t4_abort_running", running, 0);
        chk("t4_abort_test_en", test_en, 0);
        chk("t4_abort_cut_sel", cut_sel, 0);
        chk("t4_abort_pass", pass, 0);
        chk("t4_abort_bist_end", bist_end, 0);
        step(2); rst = 1'b0;
        step(20);
        chk("t4_no_end", n_end, 5);
        chk("t4_held_no_run", running, 0);
        start = 4'b0000; step(1);
        start = 4'b0010;
        step(2);
        chk("t4_rerun_sel", cut_sel, 4'b0010);
        step(10);
        chk("t4_rerun_end", bist_end, 1);
        chk("t4_rerun_id", result_id, 1);
        step(1);

        // all requesters, repeated: order 0,1,2,3,0
        rst = 1'b1; start = 4'b0000; step(2); rst = 1'b0; step(1);
        q_sel.delete();
        start = 4'b1111;
        step(4); start = 4'b0000;
        step(12); start = 4'b1111;
        for (int i = 0; i < 100 && q_sel.size() < 5; i++) step(1);
        step(20);
        chk("t5_run_count", q_sel.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t5_grant_%0d", i), i < q_sel.size() ? q_sel[i] : 4'bxxxx, exp_sel[i]);
        chk("t5_n_end", n_end, 11);
        chk("onehot_violations", n_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
